// File: rtl/cas_player.sv
// cas_player: cassette playback transmitter.
// Serialises bytes from a valid/ready stream LSB-first as FSK square waves.
// Each bit is one full period: high for H cycles, then low for H cycles,
// where H depends on the bit value. A holding register lets the next byte
// be reloaded on the same edge that the last low half ends, so consecutive
// bytes play without a gap.
module cas_player #(
  parameter int unsigned HALF_0 = 23863,
  parameter int unsigned HALF_1 = 11932
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       motor,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       casdout,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [15:0] H0_M1 = 16'(HALF_0 - 1);
  localparam logic [15:0] H1_M1 = 16'(HALF_1 - 1);

  // Half-period reload value (H - 1) for a given bit value.
  function automatic logic [15:0] half_m1(input logic bit_v);
    return bit_v ? H1_M1 : H0_M1;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [7:0]  shf_r, shf_s;
  logic [2:0]  bitn_r, bitn_s;
  logic [7:0]  hold_r, hold_s;
  logic        hold_full_r, hold_full_s;
  logic        casdout_r, casdout_s;
  logic        byte_ready_r;
  logic        busy_r;
  logic        load_now_s;
  logic        accept_s;

  // Next-state, counter, shifter and output-level decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    shf_s      = shf_r;
    bitn_s     = bitn_r;
    casdout_s  = casdout_r;
    load_now_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        casdout_s = 1'b0;
        if (motor && hold_full_r) begin
          load_now_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (!motor) begin
          state_s   = ST_IDLE;
          casdout_s = 1'b0;
        end else if (cnt_r != 16'd0) begin
          cnt_s = cnt_r - 16'd1;
        end else begin
          casdout_s = 1'b0;
          cnt_s     = half_m1(shf_r[0]);
          state_s   = ST_LOW;
        end
      end
      ST_LOW: begin
        if (!motor) begin
          state_s   = ST_IDLE;
          casdout_s = 1'b0;
        end else if (cnt_r != 16'd0) begin
          cnt_s = cnt_r - 16'd1;
        end else if (bitn_r != 3'd7) begin
          shf_s     = shf_r >> 1;
          bitn_s    = bitn_r + 3'd1;
          cnt_s     = half_m1(shf_r[1]);
          casdout_s = 1'b1;
          state_s   = ST_HIGH;
        end else if (hold_full_r) begin
          load_now_s = 1'b1;
        end else begin
          state_s   = ST_IDLE;
          casdout_s = 1'b0;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        casdout_s = 1'b0;
      end
    endcase
    // A reload from the holding register starts the first high half at once.
    if (load_now_s) begin
      shf_s     = hold_r;
      bitn_s    = 3'd0;
      cnt_s     = half_m1(hold_r[0]);
      casdout_s = 1'b1;
      state_s   = ST_HIGH;
    end else begin
      shf_s = shf_s;
    end
  end

  // Holding register: an accept on the load edge wins, since hold is read before it is overwritten.
  always_comb begin
    accept_s    = byte_valid & byte_ready_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    if (accept_s) begin
      hold_s      = byte_data;
      hold_full_s = 1'b1;
    end else if (load_now_s) begin
      hold_full_s = 1'b0;
    end else begin
      hold_full_s = hold_full_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 16'd0;
      shf_r        <= 8'd0;
      bitn_r       <= 3'd0;
      hold_r       <= 8'd0;
      hold_full_r  <= 1'b0;
      casdout_r    <= 1'b0;
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      shf_r        <= shf_s;
      bitn_r       <= bitn_s;
      hold_r       <= hold_s;
      hold_full_r  <= hold_full_s;
      casdout_r    <= casdout_s;
      byte_ready_r <= ~hold_full_s;
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign byte_ready = byte_ready_r;
  assign casdout    = casdout_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player: small half-periods for protocol scenarios,
// plus a second instance with default half-periods for timing at full scale.
module tb_cas_player;

  logic       clk;
  logic       reset;
  logic       motor;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       casdout;
  logic       busy;

  logic       motor2;
  logic [7:0] byte_data2;
  logic       byte_valid2;
  logic       byte_ready2;
  logic       casdout2;
  logic       busy2;

  int n_checks = 0;
  int n_errors = 0;

  cas_player #(.HALF_0(8), .HALF_1(4)) dut (
    .clk(clk), .reset(reset), .motor(motor), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .casdout(casdout), .busy(busy)
  );

  cas_player dut_def (
    .clk(clk), .reset(reset), .motor(motor2), .byte_data(byte_data2),
    .byte_valid(byte_valid2), .byte_ready(byte_ready2), .casdout(casdout2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  // Expected byte duration in cycles for HALF_0=8, HALF_1=4.
  function automatic int exp_len(input logic [7:0] b);
    int s = 0;
    for (int i = 0; i < 8; i++) s += b[i] ? 8 : 16;
    return s;
  endfunction

  task automatic send(input logic [7:0] d);
    int n = 0;
    byte_data  = d;
    byte_valid = 1'b1;
    while (!byte_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 32'(n < 1000), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (!casdout && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rise_timeout", 32'(n < 500), 32'd1);
  endtask

  task automatic meas_half(input logic lvl, output int len);
    len = 0;
    while (casdout === lvl && busy === 1'b1 && len < 100) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic recv_byte(output logic [7:0] b, output int total);
    int hi, lo;
    total = 0;
    b = 8'd0;
    for (int i = 0; i < 8; i++) begin
      meas_half(1'b1, hi);
      meas_half(1'b0, lo);
      b[i] = (hi == 4);
      total += hi + lo;
    end
  endtask

  int          a5_tab [16] = '{4,4,8,8,4,4,8,8,8,8,4,4,8,8,4,4};
  int          n, len, total, t1, t2, t3;
  logic [7:0]  b1, b2, b3;
  logic        bad;

  initial begin
    reset = 1'b0; motor = 1'b0; byte_data = 8'd0; byte_valid = 1'b0;
    motor2 = 1'b1; byte_data2 = 8'd0; byte_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_casdout", 32'(casdout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready_rise", 32'(byte_ready), 32'd1);

    // Single byte 0xA5
    motor = 1'b1;
    send(8'hA5);
    wait_rise(n);
    chk("a5_latency", 32'(n), 32'd1);
    chk("a5_busy_up", 32'(busy), 32'd1);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      meas_half(i[0] ? 1'b0 : 1'b1, len);
      chk($sformatf("a5_half%0d", i), 32'(len), 32'(a5_tab[i]));
      total += len;
    end
    chk("a5_total", 32'(total), 32'd96);
    chk("a5_busy_end", 32'(busy), 32'd0);
    chk("a5_cas_end", 32'(casdout), 32'd0);

    // Back-to-back 0x00 then 0xFF
    repeat (3) @(negedge clk);
    fork
      begin
        send(8'h00);
        send(8'hFF);
      end
      begin
        wait_rise(n);
        total = 0;
        for (int i = 0; i < 32; i++) begin
          meas_half(i[0] ? 1'b0 : 1'b1, len);
          chk($sformatf("b2b_half%0d", i), 32'(len), (i < 16) ? 32'd8 : 32'd4);
          total += len;
        end
        chk("b2b_total", 32'(total), 32'd192);
        chk("b2b_busy_end", 32'(busy), 32'd0);
      end
    join

    // Backpressure with motor off
    motor = 1'b0;
    repeat (3) @(negedge clk);
    byte_data = 8'h11; byte_valid = 1'b1;
    @(negedge clk);
    chk("bp_acc1", 32'(byte_ready), 32'd0);
    byte_data = 8'h22;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (casdout || byte_ready) bad = 1'b1;
    end
    chk("bp_stalled", 32'(bad), 32'd0);
    motor = 1'b1;
    fork
      begin
        wait_rise(n);
        recv_byte(b1, t1);
        recv_byte(b2, t2);
        recv_byte(b3, t3);
      end
      begin
        @(negedge clk);
        chk("bp_cas_up", 32'(casdout), 32'd1);
        chk("bp_ready_up", 32'(byte_ready), 32'd1);
        @(negedge clk);
        chk("bp_acc2", 32'(byte_ready), 32'd0);
        byte_data = 8'h33;
        n = 0;
        while (!byte_ready && n < 500) begin
          @(negedge clk);
          n++;
        end
        chk("bp_acc3_timeout", 32'(n < 500), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
      end
    join
    chk("bp_byte1", 32'(b1), 32'h11);
    chk("bp_byte2", 32'(b2), 32'h22);
    chk("bp_byte3", 32'(b3), 32'h33);
    chk("bp_len", 32'(t1 + t2 + t3), 32'(exp_len(8'h11) + exp_len(8'h22) + exp_len(8'h33)));
    chk("bp_busy_end", 32'(busy), 32'd0);

    // Motor drop mid bit 3 of 0x55 with 0x12 held
    repeat (3) @(negedge clk);
    send(8'h55);
    wait_rise(n);
    send(8'h12);
    repeat (34) @(negedge clk);
    chk("md_mid_high", 32'(casdout), 32'd1);
    motor = 1'b0;
    @(negedge clk);
    chk("md_cas_off", 32'(casdout), 32'd0);
    chk("md_busy_off", 32'(busy), 32'd0);
    chk("md_hold_kept", 32'(byte_ready), 32'd0);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (casdout || busy) bad = 1'b1;
    end
    chk("md_quiet", 32'(bad), 32'd0);
    motor = 1'b1;
    wait_rise(n);
    chk("md_restart_lat", 32'(n), 32'd1);
    recv_byte(b1, t1);
    chk("md_byte", 32'(b1), 32'h12);
    chk("md_len", 32'(t1), 32'(exp_len(8'h12)));

    // Reset during a high half
    repeat (3) @(negedge clk);
    send(8'hF0);
    wait_rise(n);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rm_cas", 32'(casdout), 32'd0);
    chk("rm_ready", 32'(byte_ready), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rm_ready_rise", 32'(byte_ready), 32'd1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (casdout || busy) bad = 1'b1;
    end
    chk("rm_no_residual", 32'(bad), 32'd0);

    // Default parameters: byte 0x01 on the second instance
    byte_data2 = 8'h01; byte_valid2 = 1'b1;
    @(negedge clk);
    byte_valid2 = 1'b0;
    n = 0;
    while (!casdout2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("def_rise", 32'(casdout2), 32'd1);
    len = 0;
    while (casdout2 && len < 30000) begin
      len++;
      @(negedge clk);
    end
    chk("def_bit0_high", 32'(len), 32'd11932);
    len = 0;
    while (!casdout2 && len < 30000) begin
      len++;
      @(negedge clk);
    end
    chk("def_bit0_low", 32'(len), 32'd11932);
    len = 0;
    while (casdout2 && len < 30000) begin
      len++;
      @(negedge clk);
    end
    chk("def_bit1_high", 32'(len), 32'd23863);
    motor2 = 1'b0;
    @(negedge clk);
    chk("def_stop", 32'(busy2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
